// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

  localparam logic [2:0] OP_MULT = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_MTHI = 3'd2;
  localparam logic [2:0] OP_MTLO = 3'd3;

  localparam int unsigned ITER_COUNT = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

endpackage

// File: rtl/hilo_muldiv_core.sv
// Iterative unsigned datapath: shift-add multiply / restoring divide over ITER_COUNT steps.
// Divider datapath present only when MULDIV_DIV_EN is defined.
module muldiv_core
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_div,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_last,
  output logic [2*WIDTH-1:0] o_acc
);

  localparam int unsigned CNT_W = $clog2(ITER_COUNT);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_mul_nx;
  logic [2*WIDTH-1:0] w_acc_nx;

  // Multiply: upper half accumulates, multiplier shifts out of the low end.
  assign w_add    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
  assign w_mul_nx = r_acc[0] ? {w_add, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  logic           r_div;
  logic [WIDTH:0] w_sh;
  logic [WIDTH:0] w_sub;
  logic           w_ge;

  // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign w_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_sub = w_sh - {1'b0, r_b};
  assign w_ge  = (w_sh >= {1'b0, r_b});

  always_comb begin
    w_acc_nx = w_mul_nx;
    if (r_div) begin
      w_acc_nx = w_ge ? {w_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                      : {w_sh[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_div <= 1'b0;
    else if (i_load) r_div <= i_div;
  end
`else
  logic w_unused_div;
  assign w_unused_div = i_div;
  assign w_acc_nx     = w_mul_nx;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_acc <= {{WIDTH{1'b0}}, i_a};
      r_b   <= i_b;
      r_cnt <= '0;
    end else if (i_step) begin
      r_acc <= w_acc_nx;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_last = (r_cnt == CNT_W'(ITER_COUNT - 1));
  assign o_acc  = r_acc;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO owner: FSM, sign handling and result registers around muldiv_core.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV completes as a no-op.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             r_state, w_state_nx;
  logic               r_busy, r_done, r_div_zero, r_neg_p;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               w_accept, w_last;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0] w_acc, w_prod_fix;
`ifdef MULDIV_DIV_EN
  logic               r_neg_r, r_is_div;
`endif

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_mag_a    = (signed_op && a[WIDTH-1]) ? -a : a;
  assign w_mag_b    = (signed_op && b[WIDTH-1]) ? -b : b;
  assign w_prod_fix = r_neg_p ? -w_acc : w_acc;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_accept),
    .i_div  (op == OP_DIV),
    .i_step ((r_state == S_MUL) || (r_state == S_DIV)),
    .i_a    (w_mag_a),
    .i_b    (w_mag_b),
    .o_last (w_last),
    .o_acc  (w_acc)
  );

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MULT) w_state_nx = S_MUL;
`ifdef MULDIV_DIV_EN
          else if (op == OP_DIV && b != '0) w_state_nx = S_DIV;
`endif
          else w_state_nx = S_DONE;
        end
      end
      S_MUL, S_DIV: if (w_last) w_state_nx = S_FIX;
      S_FIX:        w_state_nx = S_DONE;
      S_DONE:       w_state_nx = S_IDLE;
      default:      w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_neg_p    <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
`ifdef MULDIV_DIV_EN
      r_neg_r    <= 1'b0;
      r_is_div   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx != S_IDLE);
      r_done  <= (w_state_nx == S_DONE);
      if (w_accept) begin
        r_neg_p <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
        r_neg_r    <= signed_op & a[WIDTH-1];
        r_is_div   <= (op == OP_DIV);
        r_div_zero <= (op == OP_DIV) && (b == '0);
`else
        r_div_zero <= 1'b0;
`endif
        if (op == OP_MTHI) r_hi <= a;
        if (op == OP_MTLO) r_lo <= a;
      end
      // The dangling else falls through to the product write when no divider is built.
      if (r_state == S_FIX) begin
`ifdef MULDIV_DIV_EN
        if (r_is_div) begin
          r_lo <= r_neg_p ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
          r_hi <= r_neg_r ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];
        end else
`endif
        {r_hi, r_lo} <= w_prod_fix;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv (expectations follow MULDIV_DIV_EN).
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        signed_op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] e_hi, e_lo;
  int          e_cyc;
  logic        e_dz;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op, follow it to done (bounded), optionally poke start while busy.
  task automatic run_op(input string tag, input logic [2:0] o, input logic s,
                        input logic [31:0] va, input logic [31:0] vb,
                        input int exp_cyc, input int inj);
    logic [31:0] p_hi, p_lo;
    int cyc;
    bit seen, busy_bad;
    p_hi = hi;
    p_lo = lo;
    seen = 0;
    busy_bad = 0;
    @(negedge clk);
    start = 1'b1; op = o; signed_op = s; a = va; b = vb;
    @(posedge clk);
    #1;
    start = 1'b0; a = '0; b = '0;
    for (cyc = 1; cyc <= 60; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk);
        #1;
      end
      start = (inj != 0 && cyc == inj);
      if (start) begin
        op = 3'd2;
        a  = 32'hBAD0BAD0;
      end
      if (cyc == 20) begin
        chk({tag, "_hold_hi"}, hi, p_hi);
        chk({tag, "_hold_lo"}, lo, p_lo);
      end
      if (done) begin
        seen = 1;
        break;
      end
      if (!busy) busy_bad = 1;
    end
    start = 1'b0;
    chk({tag, "_done_cyc"}, seen ? cyc : 0, exp_cyc);
    chk({tag, "_busy_held"}, busy_bad, 0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic chk_result(input string tag);
    chk({tag, "_hi"}, hi, e_hi);
    chk({tag, "_lo"}, lo, e_lo);
    chk({tag, "_dz"}, div_zero, e_dz);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dz", div_zero, 1'b0);

    e_dz = 1'b0;
    run_op("mul_u", 3'd0, 1'b0, 32'hFFFFFFFF, 32'd2, 34, 0);
    e_hi = 32'h00000001; e_lo = 32'hFFFFFFFE;
    chk_result("mul_u");

    run_op("mul_s", 3'd0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFF8, 34, 10);
    e_hi = 32'h0; e_lo = 32'h00000020;
    chk_result("mul_s");

`ifdef MULDIV_DIV_EN
    e_cyc = 34; e_hi = 32'd2; e_lo = 32'hFFFFFFFD;
`else
    e_cyc = 1;
`endif
    run_op("div_s", 3'd1, 1'b1, 32'd32, 32'hFFFFFFF6, e_cyc, 0);
    chk_result("div_s");

`ifdef MULDIV_DIV_EN
    e_hi = 32'd2; e_lo = 32'd3;
`endif
    run_op("div_u", 3'd1, 1'b0, 32'd32, 32'd10, e_cyc, 0);
    chk_result("div_u");

`ifdef MULDIV_DIV_EN
    e_hi = 32'h0; e_lo = 32'h80000000;
`endif
    run_op("div_min", 3'd1, 1'b1, 32'h80000000, 32'hFFFFFFFF, e_cyc, 0);
    chk_result("div_min");

`ifdef MULDIV_DIV_EN
    e_dz = 1'b1;
`endif
    run_op("div_zero", 3'd1, 1'b0, 32'd5, 32'd0, 1, 0);
    chk_result("div_zero");

    e_dz = 1'b0; e_lo = 32'h12345678;
    run_op("mtlo", 3'd3, 1'b0, 32'h12345678, 32'h0, 1, 0);
    chk_result("mtlo");

    e_hi = 32'hDEADBEEF;
    run_op("mthi", 3'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1, 0);
    chk_result("mthi");

    run_op("rsvd", 3'd5, 1'b0, 32'h55555555, 32'hAAAAAAAA, 1, 0);
    chk_result("rsvd");

    run_op("mul_mix", 3'd0, 1'b1, 32'hFFFFFFFD, 32'd7, 34, 0);
    e_hi = 32'hFFFFFFFF; e_lo = 32'hFFFFFFEB;
    chk_result("mul_mix");

    // Abort a MULT in cycle 15 with an asynchronous reset pulse.
    begin
      bit got_done;
      got_done = 0;
      @(negedge clk);
      start = 1'b1; op = 3'd0; signed_op = 1'b0; a = 32'd7; b = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("abort_hi", hi, 32'h0);
      chk("abort_lo", lo, 32'h0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      #2;
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (done) got_done = 1;
      end
      chk("abort_no_done", got_done, 1'b0);
    end

    e_hi = 32'h0; e_lo = 32'h0; e_dz = 1'b0;
    run_op("mul_7x6", 3'd0, 1'b0, 32'd7, 32'd6, 34, 0);
    e_lo = 32'd42;
    chk_result("mul_7x6");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
